// File: rtl/rotate_pkg.sv
// Shared types and beat layout for the derotation path: the sequencer and the
// CORDIC rotator both use these helpers, so the {phase, q, i} packing stays consistent.
package rotate_pkg;

    localparam int AMP_W = 16;
    localparam int ARG_W = 2 * AMP_W;

    typedef logic signed [AMP_W-1:0] amp_t;
    typedef logic        [ARG_W-1:0] arg_t;
    typedef arg_t                    acc_t;

    // Phase full scale is 2*pi, so pi is the MSB of the phase word.
    localparam arg_t PI   = arg_t'(1) << (ARG_W - 1);
    localparam arg_t PI_2 = arg_t'(1) << (ARG_W - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Beat layout for a sample width w: {phase(2w), q(w), i(w)}.
    function automatic int beat_i_lsb(input int w);
        beat_i_lsb = 0 * w;
    endfunction

    function automatic int beat_q_lsb(input int w);
        beat_q_lsb = w;
    endfunction

    function automatic int beat_ph_lsb(input int w);
        beat_ph_lsb = 2 * w;
    endfunction

    function automatic int beat_w(input int w);
        beat_w = 4 * w;
    endfunction

    // Default-width pack/unpack helpers for consumers built at AMP_W.
    function automatic logic [4*AMP_W-1:0] pack_beat(input arg_t ph, input amp_t q, input amp_t i);
        pack_beat = {ph, q, i};
    endfunction

    function automatic arg_t beat_phase(input logic [4*AMP_W-1:0] b);
        beat_phase = b[4*AMP_W-1:2*AMP_W];
    endfunction

endpackage

// File: rtl/phase_acc.sv
// Loadable modular phase accumulator: load sets value and step size, each step
// adds the step size (two's complement, wraps silently). Usable by any NCO.
module phase_acc #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] load_inc_i,
    input  logic         step_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] inc_q;

    // Load takes priority over step; reset clears both value and step size.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
            inc_q <= '0;
        end else if (load_i) begin
            acc_q <= load_val_i;
            inc_q <= load_inc_i;
        end else if (step_i) begin
            acc_q <= acc_q + inc_q;
        end
    end

    assign value_o = acc_q;

endmodule

// File: rtl/rotate_ctrl.sv
// Frame sequencer for the CORDIC rotator: takes one {start, inc} config per
// frame, tags each I/Q sample with the running phase and emits {phase, q, i}
// beats through a single-entry output register, cutting frames at MAX_LEN.
module rotate_ctrl
    import rotate_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int MAX_LEN = 4096,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [4*WIDTH-1:0] cfg_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [2*WIDTH-1:0] s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [4*WIDTH-1:0] m_data,
    output logic               m_last,
    output logic               busy,
    output logic               trunc,
    output logic [CW-1:0]      count
);

    localparam int PH_LSB = beat_ph_lsb(WIDTH);
    localparam int Q_LSB  = beat_q_lsb(WIDTH);
    localparam int I_LSB  = beat_i_lsb(WIDTH);
    localparam int BW     = beat_w(WIDTH);

    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

    state_e              state_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic [BW-1:0]       m_data_q;
    logic                trunc_q;
    logic [CW-1:0]       count_q;
    logic [2*WIDTH-1:0]  acc;

    logic cfg_hs;
    logic s_hs;
    logic out_hs;
    logic at_max;
    logic last_d;

    // Handshakes; s_ready looks through m_ready so the output register refills
    // in the same cycle it drains (one beat per cycle).
    assign cfg_ready = (state_q == IDLE);
    assign s_ready   = (state_q == RUN) && (!m_valid_q || m_ready);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign s_hs      = s_valid && s_ready;
    assign out_hs    = m_valid_q && m_ready;
    assign at_max    = (count_q == LAST_CNT);
    assign last_d    = s_last || at_max;

    phase_acc #(
        .W (2 * WIDTH)
    ) u_phase_acc (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (cfg_hs),
        .load_val_i (cfg_data[4*WIDTH-1:2*WIDTH]),
        .load_inc_i (cfg_data[2*WIDTH-1:0]),
        .step_i     (s_hs),
        .value_o    (acc)
    );

    // Frame FSM plus output register; the phase attached to a beat is the
    // accumulator value before this sample's step, so sample 0 gets start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            trunc_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            trunc_q <= 1'b0;
            if (out_hs) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (cfg_hs) begin
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (s_hs) begin
                        m_data_q[PH_LSB +: 2*WIDTH] <= acc;
                        m_data_q[Q_LSB  +: WIDTH]   <= s_data[2*WIDTH-1:WIDTH];
                        m_data_q[I_LSB  +: WIDTH]   <= s_data[WIDTH-1:0];
                        m_valid_q <= 1'b1;
                        m_last_q  <= last_d;
                        count_q   <= count_q + CW'(1);
                        if (last_d) begin
                            state_q <= DRAIN;
                        end
                        if (at_max && !s_last) begin
                            trunc_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs && m_last_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;
    assign trunc   = trunc_q;
    assign count   = count_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/rotate_ctrl.md
Name: rotate_ctrl

Overview:
Frame sequencer for the CORDIC rotator in the derotation path. It accepts one configuration word per frame: start phase and per-sample phase increment. It then streams I/Q samples, attaches a running phase accumulator value to each sample, and emits packed {phase, q, i} beats that feed the rotator's input stream directly. It also enforces a maximum frame length and reports frame status.

Parameters:
WIDTH, 16, sample component width; phase word is 2*WIDTH bits, with full scale equal to 2*pi.
MAX_LEN, 4096, maximum samples per frame before forced termination (>= 2).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_valid  in  1  config beat valid
cfg_ready  out  1  config accepted when high with cfg_valid
cfg_data  in  4*WIDTH  [4W-1:2W] start phase, [2W-1:0] signed phase increment
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_data  in  2*WIDTH  {q, i}, each signed WIDTH
s_last  in  1  final sample of frame
m_valid  out  1  rotator beat valid
m_ready  in  1  rotator ready
m_data  out  4*WIDTH  {phase(2W), q(W), i(W)}
m_last  out  1  final beat of frame
busy  out  1  high in RUN or DRAIN
trunc  out  1  one-cycle pulse when a frame is cut at MAX_LEN
count  out  $clog2(MAX_LEN+1)  samples accepted in current/last frame

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, m_valid=0, m_last=0, m_data=0, trunc=0, count=0, busy=0, acc=0, inc=0.
- State IDLE: cfg_ready=1, s_ready=0. On cfg handshake: acc<=start, inc<=increment, count<=0, go to RUN.
- State RUN: cfg_ready=0, s_ready = !m_valid || m_ready (single-entry output register).
- Sample handshake in RUN:
  - m_data <= {acc, q, i}; acc <= acc + inc (modulo 2^(2W), wraps silently); count <= count+1; m_valid <= 1.
  - m_last <= s_last || (count == MAX_LEN-1).
  - If m_last is being set, go to DRAIN.
  - If the cut is due to MAX_LEN and s_last is 0, pulse trunc for one cycle.
- The first sample of a frame carries exactly the start phase; sample k carries start + k*inc.
- State DRAIN: cfg_ready=0, s_ready=0. On m_valid && m_ready && m_last: m_valid<=0, go to IDLE.
- Output hold rule: when m_ready is low, m_valid stays high and m_data and m_last are stable.
- When the output is not refilled, m_valid clears on m_ready.
- Latency: 1 cycle from input handshake to m_valid. Full throughput (1 beat/cycle) while m_ready=1.
- Samples presented in IDLE are stalled (s_ready=0), never dropped or passed.
- cfg_valid in RUN/DRAIN is stalled until IDLE.
- cfg_valid and reset in the same cycle: reset wins and cfg is not accepted.
- Reset mid-frame: immediate return to IDLE; the pending output beat is discarded (m_valid=0 next cycle).
- count holds its final value in IDLE until the next cfg handshake.
- busy = (state != IDLE).
- No combinational path from m_ready to m_valid. s_ready may depend combinationally on m_ready.
- Phase arithmetic is unsigned modular 2W-bit; inc is interpreted two's complement, so a negative inc decrements.

Decomposition:
- Shared package rotate_pkg holds:
  - amp_t (signed WIDTH), arg_t (2W phase), acc_t.
  - Constants PI, PI_2.
  - A state enum {IDLE, RUN, DRAIN}.
  - Field-slice helpers for the {phase,q,i} packing, so rotate_ctrl and the rotator agree on layout.
- One natural sub-module, phase_acc: loadable 2W-bit accumulator with load, step and value ports, reusable by other NCO users.

Test Plan:
1. Ramp: cfg start=0x0000_0000, inc=0x1000_0000; 4 samples (i=100*k, q=-k), last on 4th -> m_data phases 0x00000000, 0x10000000, 0x20000000, 0x30000000 with matching i/q; m_last only on beat 4; count=4; back to IDLE with cfg_ready=1.
2. Wrap/negative: start=0x7000_0000, inc=0x2000_0000 -> phases 0x70000000, 0x90000000, 0xB0000000. Then start=0x0000_0000, inc=0xF000_0000 -> phases 0x00000000, 0xF0000000.
3. Backpressure: m_ready toggles 1,0,0,1 with s_valid held high -> no beat lost or duplicated; m_data stable while m_ready=0; phase sequence unbroken.
4. Truncation: MAX_LEN=8, 10 samples with no s_last -> 8 beats output, m_last on beat 8, trunc pulses once, samples 9-10 stalled (s_ready=0) until the next cfg.
5. Ordering: samples presented before cfg -> s_ready=0, no m_valid. cfg during RUN -> cfg_ready=0 until the last beat handshakes out.
6. Reset mid-frame: assert reset after beat 2 with m_ready=0 -> next cycle m_valid=0, busy=0, cfg_ready=1; the next frame starts at its configured start phase.
